// File: rtl/stack_unit_if.sv
// Operand-stack port bundle between the controller and stack_unit.
//   master: controller side - drives push/pop/tos/MtoS strobes and the two
//           candidate write-data sources (memData, aluRes); observes
//           stackOut, count, empty, full, overflow, underflow.
//   slave : stack side - the reverse directions.
interface stack_unit_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  logic                     push;
  logic                     pop;
  logic                     tos;
  logic                     MtoS;
  logic [WIDTH-1:0]         memData;
  logic [WIDTH-1:0]         aluRes;
  logic [WIDTH-1:0]         stackOut;
  logic [$clog2(DEPTH):0]   count;
  logic                     empty;
  logic                     full;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output push, pop, tos, MtoS, memData, aluRes,
    input  stackOut, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, tos, MtoS, memData, aluRes,
    output stackOut, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/stack_unit.sv
// Hardware operand stack for the multicycle stack CPU.
//   clk, rst : clock and synchronous active-high reset
//   bus      : stack_unit_if slave port
//     push/pop/tos/MtoS     : controller strobes; MtoS picks memData (1) or aluRes (0)
//     memData/aluRes        : candidate push data
//     stackOut              : registered top/popped value
//     count/empty/full      : occupancy (empty/full are combinational)
//     overflow/underflow    : sticky error flags, cleared only by rst
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  stack_unit_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp, sp_next;
  logic [AW-1:0]    top_idx, wr_idx;
  logic [WIDTH-1:0] stack_out, wd;
  logic             empty, full, overflow, underflow;
  logic             wr_en, load_out, set_ovf, set_unf;

  always_comb begin
    wd       = bus.MtoS ? bus.memData : bus.aluRes;
    empty    = (sp == '0);
    full     = (sp == CW'(DEPTH));
    top_idx  = sp[AW-1:0] - AW'(1);
    sp_next  = sp;
    wr_en    = 1'b0;
    wr_idx   = sp[AW-1:0];
    load_out = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    if (bus.pop) begin
      // pop wins over tos; push+pop on a non-empty stack overwrites the top in place
      if (!empty) begin
        load_out = 1'b1;
        if (bus.push) begin
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else begin
          sp_next = sp - CW'(1);
        end
      end else begin
        set_unf = 1'b1;
        if (bus.push) begin
          wr_en   = 1'b1;
          sp_next = sp + CW'(1);
        end
      end
    end else begin
      if (bus.tos) begin
        if (!empty) load_out = 1'b1;
        else        set_unf  = 1'b1;
      end
      if (bus.push) begin
        if (!full) begin
          wr_en   = 1'b1;
          sp_next = sp + CW'(1);
        end else begin
          set_ovf = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= '0;
      stack_out <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp <= sp_next;
      if (load_out) stack_out <= mem[top_idx];
      if (set_ovf)  overflow  <= 1'b1;
      if (set_unf)  underflow <= 1'b1;
    end
  end

  // Array contents are deliberately not reset; reads only happen when sp>0.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_idx] <= wd;
  end

  assign bus.stackOut  = stack_out;
  assign bus.count     = sp;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit (WIDTH=8, DEPTH=8) against a queue model.
module tb_stack_unit;
  localparam int W = 8;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_unit_if #(.WIDTH(W), .DEPTH(D)) bus ();

  stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a queue whose back is the top of stack.
  logic [W-1:0] mq [$];
  logic [W-1:0] m_out = '0;
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;

  function automatic logic [15:0] exp_vec();
    logic [3:0] c;
    c = 4'(mq.size());
    return {m_out, c, (mq.size() == 0), (mq.size() == D), m_ovf, m_unf};
  endfunction

  logic [15:0] act_vec;
  assign act_vec = {bus.stackOut, bus.count, bus.empty, bus.full, bus.overflow, bus.underflow};

  function automatic void model_step(bit r, bit p, bit po, bit t, logic [W-1:0] wd);
    if (r) begin
      mq.delete();
      m_out = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (po) begin
      if (mq.size() > 0) begin
        m_out = mq[mq.size()-1];
        if (p) mq[mq.size()-1] = wd;
        else   void'(mq.pop_back());
      end else begin
        m_unf = 1'b1;
        if (p) mq.push_back(wd);
      end
    end else begin
      if (t) begin
        if (mq.size() > 0) m_out = mq[mq.size()-1];
        else               m_unf = 1'b1;
      end
      if (p) begin
        if (mq.size() < D) mq.push_back(wd);
        else               m_ovf = 1'b1;
      end
    end
  endfunction

  // Apply one cycle of stimulus, let the edge happen, advance the model.
  task automatic drive(bit r, bit p, bit po, bit t, bit m, logic [W-1:0] md, logic [W-1:0] ar);
    rst = r; bus.push = p; bus.pop = po; bus.tos = t;
    bus.MtoS = m; bus.memData = md; bus.aluRes = ar;
    @(posedge clk);
    #1;
    model_step(r, p, po, t, m ? md : ar);
    rst = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 0, 1, 8'hA5, 8'h00);
    n_cmp++;
    if (act_vec !== exp_vec()) begin
      n_bad++; $display("FAIL reset_with_push: got %h want %h", act_vec, exp_vec());
    end
    n_cmp++;
    if (bus.empty !== 1'b1 || bus.count !== 4'd0 || bus.stackOut !== 8'h00) begin
      n_bad++; $display("FAIL reset_state: got out=%h cnt=%0d empty=%b want 00/0/1",
                        bus.stackOut, bus.count, bus.empty);
    end
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    n_cmp++;
    if (act_vec !== exp_vec()) begin
      n_bad++; $display("FAIL reset_idle: got %h want %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_push_pop();
    logic [W-1:0] want [3];
    want[0] = 8'h33; want[1] = 8'h22; want[2] = 8'h11;
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 8'h11, 8'hEE);
    drive(0, 1, 0, 0, 0, 8'hEE, 8'h22);
    drive(0, 1, 0, 0, 1, 8'h33, 8'hEE);
    n_cmp++;
    if (bus.count !== 4'd3) begin
      n_bad++; $display("FAIL push3_count: got %0d want 3", bus.count);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0, 0, 0);
      n_cmp++;
      if (bus.stackOut !== want[i] || bus.count !== 4'(2 - i)) begin
        n_bad++; $display("FAIL pop_seq%0d: got out=%h cnt=%0d want %h/%0d",
                          i, bus.stackOut, bus.count, want[i], 2 - i);
      end
    end
  endtask

  task automatic test_tos();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 8'h5A, 8'h00);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 0, 0, 0);
      n_cmp++;
      if (bus.stackOut !== 8'h5A || bus.count !== 4'd1) begin
        n_bad++; $display("FAIL tos%0d: got out=%h cnt=%0d want 5a/1", i, bus.stackOut, bus.count);
      end
    end
  endtask

  task automatic test_full_overflow();
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) drive(0, 1, 0, 0, 1, 8'(i), 8'h00);
    n_cmp++;
    if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
      n_bad++; $display("FAIL full: got full=%b ovf=%b want 1/0", bus.full, bus.overflow);
    end
    drive(0, 1, 0, 0, 1, 8'h09, 8'h00);
    n_cmp++;
    if (bus.count !== 4'd8 || bus.overflow !== 1'b1) begin
      n_bad++; $display("FAIL overflow: got cnt=%0d ovf=%b want 8/1", bus.count, bus.overflow);
    end
    drive(0, 0, 1, 0, 0, 0, 0);
    n_cmp++;
    if (bus.stackOut !== 8'h08 || act_vec !== exp_vec()) begin
      n_bad++; $display("FAIL pop_after_overflow: got %h want %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_underflow();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 8'h44, 8'h00);
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    n_cmp++;
    if (bus.stackOut !== 8'h44 || bus.count !== 4'd0 || bus.underflow !== 1'b1) begin
      n_bad++; $display("FAIL underflow: got out=%h cnt=%0d unf=%b want 44/0/1",
                        bus.stackOut, bus.count, bus.underflow);
    end
    drive(0, 1, 0, 0, 0, 8'h00, 8'h77);
    drive(0, 0, 1, 0, 0, 0, 0);
    n_cmp++;
    if (bus.underflow !== 1'b1 || bus.stackOut !== 8'h77) begin
      n_bad++; $display("FAIL underflow_sticky: got unf=%b out=%h want 1/77", bus.underflow, bus.stackOut);
    end
  endtask

  task automatic test_replace_top();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 8'h10, 8'h00);
    drive(0, 1, 0, 0, 1, 8'h20, 8'h00);
    drive(0, 1, 1, 0, 0, 8'hEE, 8'h99);
    n_cmp++;
    if (bus.stackOut !== 8'h20 || bus.count !== 4'd2) begin
      n_bad++; $display("FAIL replace_top: got out=%h cnt=%0d want 20/2", bus.stackOut, bus.count);
    end
    drive(0, 0, 1, 0, 0, 0, 0);
    n_cmp++;
    if (bus.stackOut !== 8'h99) begin
      n_bad++; $display("FAIL replace_pop: got %h want 99", bus.stackOut);
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 0, 0, 8'h00, 8'(8'hC0 + i));
    drive(0, 1, 1, 0, 1, 8'hAB, 8'h00);
    n_cmp++;
    if (bus.overflow !== 1'b0 || bus.count !== 4'd8 || bus.stackOut !== 8'hC7) begin
      n_bad++; $display("FAIL replace_full: got ovf=%b cnt=%0d out=%h want 0/8/c7",
                        bus.overflow, bus.count, bus.stackOut);
    end
    drive(0, 0, 1, 0, 0, 0, 0);
    n_cmp++;
    if (bus.stackOut !== 8'hAB) begin
      n_bad++; $display("FAIL replace_full_pop: got %h want ab", bus.stackOut);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 8'h3C, 8'h00);
    drive(0, 1, 0, 1, 0, 8'h00, 8'h4D);  // tos sees 3C, then 4D is pushed
    n_cmp++;
    if (bus.stackOut !== 8'h3C || bus.count !== 4'd2) begin
      n_bad++; $display("FAIL push_tos: got out=%h cnt=%0d want 3c/2", bus.stackOut, bus.count);
    end
    drive(0, 0, 1, 1, 0, 0, 0);          // pop+tos acts as pop
    n_cmp++;
    if (bus.stackOut !== 8'h4D || bus.count !== 4'd1) begin
      n_bad++; $display("FAIL pop_tos: got out=%h cnt=%0d want 4d/1", bus.stackOut, bus.count);
    end
  endtask

  task automatic test_random();
    bit r, p, po, t, m;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      p  = $urandom_range(0, 1);
      po = ($urandom_range(0, 2) == 0);
      t  = ($urandom_range(0, 3) == 0);
      m  = $urandom_range(0, 1);
      drive(r, p, po, t, m, 8'($urandom), 8'($urandom));
      n_cmp++;
      if (act_vec !== exp_vec()) begin
        n_bad++; $display("FAIL random[%0d]: got %h want %h", i, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    bus.push = 0; bus.pop = 0; bus.tos = 0; bus.MtoS = 0;
    bus.memData = '0; bus.aluRes = '0;
    test_reset();
    test_push_pop();
    test_tos();
    test_full_overflow();
    test_underflow();
    test_replace_top();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
